// File: rtl/store_drain_ctrl.sv
// Commit-side store drain: queues ROB-retired stores in order, writes each to data memory
// over a req/ack handshake, then pulses the retired inst_num back to the store buffer.
module store_drain_ctrl #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit_valid,
   input  logic [31:0]      commit_inst_num,
   input  logic [31:0]      commit_addr,
   input  logic [31:0]      commit_data,
   input  logic [2:0]       commit_funct3,
   output logic             commit_ready,
   output logic             dmem_req,
   output logic [31:0]      dmem_addr,
   output logic [31:0]      dmem_wdata,
   output logic [3:0]       dmem_wstrb,
   input  logic             dmem_ack,
   output logic             retire_valid,
   output logic [31:0]      retire_inst_num,
   output logic             misalign_err,
   output logic [PTR_W:0]   count,
   output logic             drain_idle
);

   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] inst;
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        bad;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      RETIRE = 2'd2
   } state_t;

   state_t           state;
   entry_t           fifo_q [DEPTH];
   entry_t           enc_entry;
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [31:0]      cur_inst;
   logic             full;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] count_next;

   // Byte-lane encoding is done once at push so the drain side only replays it.
   always_comb begin
      enc_entry       = '0;
      enc_entry.inst  = commit_inst_num;
      enc_entry.waddr = commit_addr[31:2];
      case (commit_funct3)
         3'b000: begin
            enc_entry.wstrb = 4'(4'b0001 << commit_addr[1:0]);
            enc_entry.wdata = {4{commit_data[7:0]}};
         end
         3'b001: begin
            enc_entry.wstrb = commit_addr[1] ? 4'b1100 : 4'b0011;
            enc_entry.wdata = {2{commit_data[15:0]}};
            enc_entry.bad   = commit_addr[0];
         end
         3'b010: begin
            enc_entry.wstrb = 4'b1111;
            enc_entry.wdata = commit_data;
            enc_entry.bad   = (commit_addr[1:0] != 2'b00);
         end
         default: begin
            enc_entry.wdata = commit_data;
            enc_entry.bad   = 1'b1;
         end
      endcase
   end

   assign head         = fifo_q[rd_ptr];
   assign full         = (count == CNT_W'(DEPTH));
   assign commit_ready = !full;
   assign drain_idle   = (count == '0) && (state == IDLE);

   // A pop frees the head slot in the same edge, so a push while full is safe then.
   always_comb begin
      pop        = ((state == REQ) && dmem_ack) ||
                   ((state == IDLE) && (count != '0) && head.bad);
      push       = commit_valid && (!full || pop);
      count_next = count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr] <= enc_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         cur_inst        <= '0;
         dmem_req        <= 1'b0;
         dmem_addr       <= '0;
         dmem_wdata      <= '0;
         dmem_wstrb      <= '0;
         retire_valid    <= 1'b0;
         retire_inst_num <= '0;
         misalign_err    <= 1'b0;
      end else begin
         retire_valid <= 1'b0;
         misalign_err <= 1'b0;
         count        <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case (state)
            IDLE: begin
               if (count != '0) begin
                  dmem_addr  <= {head.waddr, 2'b00};
                  dmem_wdata <= head.wdata;
                  dmem_wstrb <= head.wstrb;
                  cur_inst   <= head.inst;
                  if (head.bad) begin
                     state           <= RETIRE;
                     retire_valid    <= 1'b1;
                     retire_inst_num <= head.inst;
                     misalign_err    <= 1'b1;
                  end else begin
                     state    <= REQ;
                     dmem_req <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  state           <= RETIRE;
                  dmem_req        <= 1'b0;
                  retire_valid    <= 1'b1;
                  retire_inst_num <= cur_inst;
               end
            end
            RETIRE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl: lane encoding, latency, full-queue ordering,
// misaligned drop, mid-request reset and ack stall.
module tb_store_drain_ctrl;

   logic        clk;
   logic        reset;
   logic        commit_valid;
   logic [31:0] commit_inst_num;
   logic [31:0] commit_addr;
   logic [31:0] commit_data;
   logic [2:0]  commit_funct3;
   logic        commit_ready;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic        retire_valid;
   logic [31:0] retire_inst_num;
   logic        misalign_err;
   logic [3:0]  count;
   logic        drain_idle;

   int n_cmp  = 0;
   int n_fail = 0;

   store_drain_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .commit_valid    (commit_valid),
      .commit_inst_num (commit_inst_num),
      .commit_addr     (commit_addr),
      .commit_data     (commit_data),
      .commit_funct3   (commit_funct3),
      .commit_ready    (commit_ready),
      .dmem_req        (dmem_req),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_wstrb      (dmem_wstrb),
      .dmem_ack        (dmem_ack),
      .retire_valid    (retire_valid),
      .retire_inst_num (retire_inst_num),
      .misalign_err    (misalign_err),
      .count           (count),
      .drain_idle      (drain_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3);
      commit_valid    = 1'b1;
      commit_inst_num = inst;
      commit_addr     = addr;
      commit_data     = data;
      commit_funct3   = f3;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] f3);
      drive(inst, addr, data, f3);
      step();
      commit_valid = 1'b0;
   endtask

   task automatic wait_retire(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         step();
         if (retire_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_cmp++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", commit_ready); end
      n_cmp++; if (drain_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", drain_idle); end
      n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", dmem_req); end
      n_cmp++; if ({dmem_addr, dmem_wdata, dmem_wstrb} !== 68'h0) begin n_fail++;
         $display("FAIL reset_dmem got %h/%h/%h exp 0/0/0", dmem_addr, dmem_wdata, dmem_wstrb); end
      n_cmp++; if ({retire_valid, retire_inst_num, misalign_err} !== 34'h0) begin n_fail++;
         $display("FAIL reset_retire got %b/%h/%b exp 0/0/0", retire_valid, retire_inst_num, misalign_err); end
   endtask

   task automatic test_sw_latency();
      push(32'd5, 32'h100, 32'hDEADBEEF, 3'b010);
      n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL t1_count got %0d exp 1", count); end
      n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL t1_req_early got %b exp 0", dmem_req); end
      step();
      n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL t1_req got %b exp 1", dmem_req); end
      n_cmp++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL t1_addr got %h exp 00000100", dmem_addr); end
      n_cmp++; if (dmem_wstrb !== 4'b1111) begin n_fail++; $display("FAIL t1_wstrb got %b exp 1111", dmem_wstrb); end
      n_cmp++; if (dmem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_wdata got %h exp deadbeef", dmem_wdata); end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL t1_req_drop got %b exp 0", dmem_req); end
      n_cmp++; if (retire_valid !== 1'b1 || retire_inst_num !== 32'd5 || misalign_err !== 1'b0) begin n_fail++;
         $display("FAIL t1_retire got %b/%0d/%b exp 1/5/0", retire_valid, retire_inst_num, misalign_err); end
      n_cmp++; if (count !== 4'd0 || drain_idle !== 1'b0) begin n_fail++;
         $display("FAIL t1_count_pop got %0d/%b exp 0/0", count, drain_idle); end
      step();
      n_cmp++; if (retire_valid !== 1'b0 || drain_idle !== 1'b1) begin n_fail++;
         $display("FAIL t1_after got %b/%b exp 0/1", retire_valid, drain_idle); end
   endtask

   task automatic test_lanes();
      push(32'd10, 32'h203, 32'h000000A5, 3'b000);
      step();
      n_cmp++; if (dmem_addr !== 32'h200) begin n_fail++; $display("FAIL t2_sb_addr got %h exp 00000200", dmem_addr); end
      n_cmp++; if (dmem_wstrb !== 4'b1000) begin n_fail++; $display("FAIL t2_sb_wstrb got %b exp 1000", dmem_wstrb); end
      n_cmp++; if (dmem_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL t2_sb_wdata got %h exp a5a5a5a5", dmem_wdata); end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_cmp++; if (retire_valid !== 1'b1 || retire_inst_num !== 32'd10) begin n_fail++;
         $display("FAIL t2_sb_retire got %b/%0d exp 1/10", retire_valid, retire_inst_num); end
      step();
      push(32'd11, 32'h202, 32'h00001234, 3'b001);
      step();
      n_cmp++; if (dmem_addr !== 32'h200) begin n_fail++; $display("FAIL t2_sh_addr got %h exp 00000200", dmem_addr); end
      n_cmp++; if (dmem_wstrb !== 4'b1100) begin n_fail++; $display("FAIL t2_sh_wstrb got %b exp 1100", dmem_wstrb); end
      n_cmp++; if (dmem_wdata !== 32'h12341234) begin n_fail++; $display("FAIL t2_sh_wdata got %h exp 12341234", dmem_wdata); end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_cmp++; if (retire_valid !== 1'b1 || retire_inst_num !== 32'd11) begin n_fail++;
         $display("FAIL t2_sh_retire got %b/%0d exp 1/11", retire_valid, retire_inst_num); end
      step();
   endtask

   task automatic test_full_order();
      bit ok;
      for (int i = 1; i <= 8; i++) begin
         push(32'(i), 32'h300 + 32'(4 * i), 32'(i), 3'b010);
      end
      n_cmp++; if (count !== 4'd8 || commit_ready !== 1'b0) begin n_fail++;
         $display("FAIL t3_full got %0d/%b exp 8/0", count, commit_ready); end
      push(32'd99, 32'h380, 32'd99, 3'b010);
      n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL t3_ninth got %0d exp 8", count); end
      // push of inst 9 coincides with the pop of inst 1
      drive(32'd9, 32'h324, 32'd9, 3'b010);
      dmem_ack = 1'b1;
      step();
      commit_valid = 1'b0;
      n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL t3_push_pop got %0d exp 8", count); end
      n_cmp++; if (retire_valid !== 1'b1 || retire_inst_num !== 32'd1) begin n_fail++;
         $display("FAIL t3_retire_1 got %b/%0d exp 1/1", retire_valid, retire_inst_num); end
      for (int k = 2; k <= 9; k++) begin
         wait_retire(ok);
         n_cmp++; if (!ok || retire_inst_num !== 32'(k)) begin n_fail++;
            $display("FAIL t3_order got %b/%0d exp 1/%0d", ok, retire_inst_num, k); end
      end
      dmem_ack = 1'b0;
      step();
      n_cmp++; if (count !== 4'd0 || drain_idle !== 1'b1) begin n_fail++;
         $display("FAIL t3_drained got %0d/%b exp 0/1", count, drain_idle); end
   endtask

   task automatic test_misalign();
      push(32'd9, 32'h102, 32'h11111111, 3'b010);
      step();
      n_cmp++; if (retire_valid !== 1'b1 || misalign_err !== 1'b1 || retire_inst_num !== 32'd9) begin n_fail++;
         $display("FAIL t4_sw_bad got %b/%b/%0d exp 1/1/9", retire_valid, misalign_err, retire_inst_num); end
      n_cmp++; if (dmem_req !== 1'b0 || count !== 4'd0) begin n_fail++;
         $display("FAIL t4_no_req got %b/%0d exp 0/0", dmem_req, count); end
      step();
      n_cmp++; if (retire_valid !== 1'b0 || misalign_err !== 1'b0 || dmem_req !== 1'b0) begin n_fail++;
         $display("FAIL t4_after got %b/%b/%b exp 0/0/0", retire_valid, misalign_err, dmem_req); end
      push(32'd12, 32'h100, 32'h0, 3'b011);
      step();
      n_cmp++; if (retire_valid !== 1'b1 || misalign_err !== 1'b1 || retire_inst_num !== 32'd12) begin n_fail++;
         $display("FAIL t4_funct3_bad got %b/%b/%0d exp 1/1/12", retire_valid, misalign_err, retire_inst_num); end
      step();
   endtask

   task automatic test_reset_mid();
      int seen;
      for (int i = 0; i < 3; i++) begin
         push(32'(21 + i), 32'h500 + 32'(4 * i), 32'hABCD0000 + 32'(i), 3'b010);
      end
      n_cmp++; if (dmem_req !== 1'b1 || count !== 4'd3) begin n_fail++;
         $display("FAIL t5_pre got %b/%0d exp 1/3", dmem_req, count); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (dmem_req !== 1'b0 || count !== 4'd0 || drain_idle !== 1'b1 || retire_valid !== 1'b0) begin n_fail++;
         $display("FAIL t5_reset got %b/%0d/%b/%b exp 0/0/1/0", dmem_req, count, drain_idle, retire_valid); end
      seen = 0;
      dmem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (retire_valid !== 1'b0 || dmem_req !== 1'b0) seen++;
      end
      dmem_ack = 1'b0;
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL t5_quiet got %0d active cycles exp 0", seen); end
   endtask

   task automatic test_ack_stall();
      int moved;
      dmem_ack = 1'b1;
      push(32'd30, 32'h400, 32'hCAFEF00D, 3'b010);
      step();
      dmem_ack = 1'b0;
      n_cmp++; if (count !== 4'd1 || retire_valid !== 1'b0 || dmem_req !== 1'b1) begin n_fail++;
         $display("FAIL t6_stray_ack got %0d/%b/%b exp 1/0/1", count, retire_valid, dmem_req); end
      moved = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (dmem_req !== 1'b1 || dmem_addr !== 32'h400 || dmem_wdata !== 32'hCAFEF00D ||
             dmem_wstrb !== 4'b1111 || retire_valid !== 1'b0) moved++;
      end
      n_cmp++; if (moved !== 0) begin n_fail++; $display("FAIL t6_hold got %0d unstable cycles exp 0", moved); end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_cmp++; if (retire_valid !== 1'b1 || retire_inst_num !== 32'd30 || count !== 4'd0) begin n_fail++;
         $display("FAIL t6_retire got %b/%0d/%0d exp 1/30/0", retire_valid, retire_inst_num, count); end
      step();
   endtask

   initial begin
      reset           = 1'b1;
      commit_valid    = 1'b0;
      commit_inst_num = '0;
      commit_addr     = '0;
      commit_data     = '0;
      commit_funct3   = '0;
      dmem_ack        = 1'b0;
      test_reset();
      test_sw_latency();
      test_lanes();
      test_full_order();
      test_misalign();
      test_reset_mid();
      test_ack_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
